reg374_bus_arbiter: RTL and testbench

REG374_BUS_ARBITER -- requirements
Module: reg374_bus_arbiter

---
 rtl/reg374_bus_arbiter.sv | 146 ++++++++++++++
 tb/tb_reg374_bus_arbiter.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg374_bus_arbiter.sv
// Round-robin owner arbiter for octal '374 banks sharing one tristate bus.
// Grants are registered; a hold limit and dead cycles guard every handover.
module reg374_bus_arbiter #(
    parameter int NREQ     = 4,
    parameter int DEAD_CYC = 1,
    parameter int MAX_HOLD = 15
) (
    input  logic                    CLK,
    input  logic                    RESET_N,
    input  logic [NREQ-1:0]         REQ,
    input  logic [NREQ-1:0]         DONE,
    output logic [NREQ-1:0]         GNT,
    output logic [NREQ-1:0]         OENB_N,
    output logic                    BUSY,
    output logic [$clog2(NREQ)-1:0] OWNER,
    output logic                    TIMEOUT
);
    localparam int OW = $clog2(NREQ);
    localparam logic [OW:0] NREQ_W = (OW+1)'(NREQ);
    localparam logic [7:0] MAX_W = 8'(MAX_HOLD);
    localparam logic [1:0] DEAD_W = 2'(DEAD_CYC);

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        TURN
    } state_t;

    state_t state_q, state_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [OW-1:0] owner_q, owner_d;
    logic [OW-1:0] rr_q, rr_d;
    logic [7:0] hold_q, hold_d;
    logic [1:0] turn_q, turn_d;
    logic timeout_q, timeout_d;

    logic [OW-1:0] cand;
    logic [OW-1:0] win_idx;
    logic win_found;
    logic rel_done, rel_drop, rel_max;

    function automatic logic [OW-1:0] wrap_add(
        input logic [OW-1:0] base,
        input logic [OW:0]   inc
    );
        logic [OW:0] sum;
        sum = {1'b0, base} + inc;
        if (sum >= NREQ_W) begin
            sum = sum - NREQ_W;
        end
        return sum[OW-1:0];
    endfunction

    // Search starts at rr_q and wraps, so the first hit is the winner.
    always_comb begin
        cand = '0;
        win_found = 1'b0;
        win_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = wrap_add(rr_q, (OW+1)'(k));
            if (!win_found && REQ[cand]) begin
                win_found = 1'b1;
                win_idx = cand;
            end
        end
    end

    assign rel_done = DONE[owner_q];
    assign rel_drop = ~REQ[owner_q];
    assign rel_max = (MAX_HOLD != 0) && (hold_q == MAX_W);

    always_comb begin
        state_d = state_q;
        gnt_d = gnt_q;
        owner_d = owner_q;
        rr_d = rr_q;
        hold_d = hold_q;
        turn_d = turn_q;
        timeout_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d = DRIVE;
                    gnt_d = '0;
                    gnt_d[win_idx] = 1'b1;
                    owner_d = win_idx;
                    hold_d = 8'd1;
                end
            end
            DRIVE: begin
                if (rel_done || rel_drop || rel_max) begin
                    gnt_d = '0;
                    rr_d = wrap_add(owner_q, (OW+1)'(1));
                    hold_d = '0;
                    timeout_d = rel_max & ~rel_done & ~rel_drop;
                    if (DEAD_CYC > 0) begin
                        state_d = TURN;
                        turn_d = DEAD_W;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (hold_q != 8'hFF) begin
                    hold_d = hold_q + 8'd1;
                end
            end
            TURN: begin
                turn_d = turn_q - 2'd1;
                if (turn_q <= 2'd1) begin
                    state_d = IDLE;
                    turn_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= IDLE;
            gnt_q <= '0;
            owner_q <= '0;
            rr_q <= '0;
            hold_q <= '0;
            turn_q <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q <= gnt_d;
            owner_q <= owner_d;
            rr_q <= rr_d;
            hold_q <= hold_d;
            turn_q <= turn_d;
            timeout_q <= timeout_d;
        end
    end

    assign GNT = gnt_q;
    assign OENB_N = ~gnt_q;
    assign BUSY = (state_q != IDLE);
    assign OWNER = owner_q;
    assign TIMEOUT = timeout_q;

endmodule

// File: tb/tb_reg374_bus_arbiter.sv
// Bench for reg374_bus_arbiter: four parameter variants share stimulus and
// are compared every cycle against an edge-count based bus model.
module tb_reg374_bus_arbiter;

    function automatic int cfg_n(input int g);
        case (g)
            0: return 4;
            1: return 3;
            2: return 8;
            default: return 2;
        endcase
    endfunction

    function automatic int cfg_d(input int g);
        case (g)
            0: return 1;
            1: return 0;
            2: return 2;
            default: return 3;
        endcase
    endfunction

    function automatic int cfg_m(input int g);
        case (g)
            0: return 15;
            1: return 3;
            2: return 0;
            default: return 1;
        endcase
    endfunction

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [7:0] req_v = 8'h00;
    logic [7:0] done_v = 8'h00;

    logic [3:0][7:0] gnt_o;
    logic [3:0][7:0] oen_o;
    logic [3:0][2:0] own_o;
    logic [3:0] busy_o;
    logic [3:0] to_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_inst
        localparam int N = cfg_n(g);
        localparam int OW = $clog2(N);
        logic [N-1:0] gnt;
        logic [N-1:0] oenb;
        logic [OW-1:0] own;
        logic busy;
        logic tmo;

        reg374_bus_arbiter #(
            .NREQ(N),
            .DEAD_CYC(cfg_d(g)),
            .MAX_HOLD(cfg_m(g))
        ) u_dut (
            .CLK(clk),
            .RESET_N(rst_n),
            .REQ(req_v[N-1:0]),
            .DONE(done_v[N-1:0]),
            .GNT(gnt),
            .OENB_N(oenb),
            .BUSY(busy),
            .OWNER(own),
            .TIMEOUT(tmo)
        );

        assign gnt_o[g] = 8'(gnt);
        assign oen_o[g] = 8'(oenb);
        assign own_o[g] = 3'(own);
        assign busy_o[g] = busy;
        assign to_o[g] = tmo;
    end

    // Bus model: grants allowed DEAD+1 edges after a release, forced
    // release MAX edges after the grant edge, rotating start after last owner.
    int m_own [4];
    int m_last [4];
    int m_gedge [4];
    int m_redge [4];
    int m_owner [4];
    int m_to [4];
    int edge_n;
    int waitc [4][8];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edge_n = 0;
            for (int i = 0; i < 4; i++) begin
                m_own[i] = -1;
                m_last[i] = cfg_n(i) - 1;
                m_gedge[i] = 0;
                m_redge[i] = -100;
                m_owner[i] = 0;
                m_to[i] = 0;
            end
        end else begin
            edge_n++;
            for (int i = 0; i < 4; i++) begin
                int n, d, m, o, c;
                bit fin;
                n = cfg_n(i);
                d = cfg_d(i);
                m = cfg_m(i);
                o = m_own[i];
                m_to[i] = 0;
                if (o >= 0) begin
                    if (done_v[o] || !req_v[o] ||
                        (m != 0 && edge_n - m_gedge[i] == m)) begin
                        m_to[i] = (req_v[o] && !done_v[o]) ? 1 : 0;
                        m_last[i] = o;
                        m_own[i] = -1;
                        m_redge[i] = edge_n;
                    end
                end else if (edge_n > m_redge[i] + d) begin
                    fin = 0;
                    for (int k = 0; k < n; k++) begin
                        c = (m_last[i] + 1 + k) % n;
                        if (!fin && req_v[c]) begin
                            fin = 1;
                            m_own[i] = c;
                            m_gedge[i] = edge_n;
                            m_owner[i] = c;
                        end
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 4; i++) begin
            int n, eg, eb, bound, worst;
            n = cfg_n(i);
            eg = (m_own[i] >= 0) ? (1 << m_own[i]) : 0;
            eb = ((m_own[i] >= 0) || (edge_n < m_redge[i] + cfg_d(i))) ? 1 : 0;
            chk($sformatf("i%0d gnt", i), int'(gnt_o[i]), eg);
            chk($sformatf("i%0d oenb_n", i), int'(oen_o[i]), ((1 << n) - 1) & ~eg);
            chk($sformatf("i%0d busy", i), int'(busy_o[i]), eb);
            chk($sformatf("i%0d owner", i), int'(own_o[i]), m_owner[i]);
            chk($sformatf("i%0d timeout", i), int'(to_o[i]), m_to[i]);
            chk($sformatf("i%0d onehot0", i), $onehot0(gnt_o[i]) ? 1 : 0, 1);
            worst = 0;
            for (int b = 0; b < n; b++) begin
                if (rst_n && req_v[b] && !gnt_o[i][b]) begin
                    waitc[i][b]++;
                end else begin
                    waitc[i][b] = 0;
                end
                if (waitc[i][b] > worst) begin
                    worst = waitc[i][b];
                end
            end
            if (cfg_m(i) != 0) begin
                bound = n * (cfg_m(i) + cfg_d(i) + 1);
                checks++;
                if (worst > bound) begin
                    errors++;
                    $display("FAIL i%0d starve wait=%0d limit=%0d", i, worst, bound);
                end
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        check_all();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_v = 8'h00;
        done_v = 8'h00;
        repeat (3) step();
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [3:0] req;
        logic [3:0] done;
        logic [3:0] gnt;
        logic       busy;
        int         own;
    } vec_t;

    vec_t tbl [15];
    int order [6];
    int gaps [6];

    initial begin
        int ng, cnt, gapc, s, lim, dlim;

        tbl[0]  = '{4'b0101, 4'b0000, 4'b0001, 1'b1, 0};
        tbl[1]  = '{4'b0101, 4'b0000, 4'b0001, 1'b1, 0};
        tbl[2]  = '{4'b0101, 4'b0000, 4'b0001, 1'b1, 0};
        tbl[3]  = '{4'b0101, 4'b0001, 4'b0000, 1'b1, 0};
        tbl[4]  = '{4'b0101, 4'b0000, 4'b0000, 1'b0, 0};
        tbl[5]  = '{4'b0101, 4'b0000, 4'b0100, 1'b1, 2};
        tbl[6]  = '{4'b0001, 4'b0000, 4'b0000, 1'b1, 2};
        tbl[7]  = '{4'b0001, 4'b0000, 4'b0000, 1'b0, 2};
        tbl[8]  = '{4'b0001, 4'b0000, 4'b0001, 1'b1, 0};
        tbl[9]  = '{4'b0101, 4'b1000, 4'b0001, 1'b1, 0};
        tbl[10] = '{4'b0001, 4'b0000, 4'b0001, 1'b1, 0};
        tbl[11] = '{4'b0101, 4'b0000, 4'b0001, 1'b1, 0};
        tbl[12] = '{4'b0100, 4'b0000, 4'b0000, 1'b1, 0};
        tbl[13] = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 0};
        tbl[14] = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 0};

        // reset values
        rst_n = 1'b0;
        repeat (3) step();
        chk("rst gnt", int'(gnt_o[0]), 0);
        chk("rst oenb_n", int'(oen_o[0]), 15);
        chk("rst busy", int'(busy_o[0]), 0);
        chk("rst owner", int'(own_o[0]), 0);
        chk("rst timeout", int'(to_o[0]), 0);
        rst_n = 1'b1;

        // vector table on the default instance
        for (int v = 0; v < 15; v++) begin
            req_v = {4'b0000, tbl[v].req};
            done_v = {4'b0000, tbl[v].done};
            step();
            chk($sformatf("vec%0d gnt", v), int'(gnt_o[0]), int'(tbl[v].gnt));
            chk($sformatf("vec%0d busy", v), int'(busy_o[0]), int'(tbl[v].busy));
            chk($sformatf("vec%0d owner", v), int'(own_o[0]), tbl[v].own);
            chk($sformatf("vec%0d timeout", v), int'(to_o[0]), 0);
        end
        done_v = 8'h00;

        // all request, each owner finishes in its 2nd drive cycle
        do_reset();
        req_v = 8'h0F;
        ng = 0;
        cnt = 0;
        gapc = 0;
        for (int k = 0; k < 80 && ng < 6; k++) begin
            step();
            done_v = 8'h00;
            if (gnt_o[0] != 8'h00) begin
                if (cnt == 0) begin
                    order[ng] = int'(own_o[0]);
                    gaps[ng] = gapc;
                    ng++;
                end
                cnt++;
                gapc = 0;
                if (cnt == 2) done_v = gnt_o[0];
            end else begin
                cnt = 0;
                gapc++;
            end
        end
        done_v = 8'h00;
        chk("rr grant count", ng, 6);
        for (int k = 0; k < ng; k++) begin
            chk($sformatf("rr order%0d", k), order[k], k % 4);
            if (k > 0) chk($sformatf("rr gap%0d", k), gaps[k], 2);
        end

        // forced release after MAX_HOLD, then DONE at the limit
        do_reset();
        req_v = 8'h02;
        s = 0;
        while (gnt_o[0] != 8'h02 && s < 5) begin
            step();
            s++;
        end
        chk("hold grant", int'(gnt_o[0]), 2);
        cnt = 0;
        while (gnt_o[0] == 8'h02 && cnt < 40) begin
            step();
            cnt++;
        end
        chk("hold length", cnt, 15);
        chk("hold timeout", int'(to_o[0]), 1);
        chk("hold gap1 gnt", int'(gnt_o[0]), 0);
        step();
        chk("hold timeout clear", int'(to_o[0]), 0);
        chk("hold gap2 gnt", int'(gnt_o[0]), 0);
        step();
        chk("hold regrant", int'(gnt_o[0]), 2);
        repeat (14) step();
        chk("limit still granted", int'(gnt_o[0]), 2);
        done_v = 8'h02;
        step();
        done_v = 8'h00;
        chk("limit done gnt", int'(gnt_o[0]), 0);
        chk("limit done timeout", int'(to_o[0]), 0);
        chk("limit done busy", int'(busy_o[0]), 1);

        // async reset in the middle of a drive
        do_reset();
        req_v = 8'h04;
        step();
        chk("pre-reset gnt", int'(gnt_o[0]), 4);
        chk("pre-reset owner", int'(own_o[0]), 2);
        #2 rst_n = 1'b0;
        #1;
        chk("async rst gnt", int'(gnt_o[0]), 0);
        chk("async rst oenb_n", int'(oen_o[0]), 15);
        chk("async rst busy", int'(busy_o[0]), 0);
        chk("async rst owner", int'(own_o[0]), 0);
        step();
        rst_n = 1'b1;
        #1;
        chk("no grant before edge", int'(gnt_o[0]), 0);
        step();
        chk("first edge grant", int'(gnt_o[0]), 4);

        // random traffic, fast then slow toggling
        do_reset();
        for (int k = 0; k < 12000; k++) begin
            step();
            if (k == 9000) rst_n = 1'b0;
            if (k == 9002) rst_n = 1'b1;
            lim = (k < 6000) ? 8 : 32;
            dlim = (k < 6000) ? 10 : 64;
            for (int b = 0; b < 8; b++) begin
                if ($urandom_range(lim - 1) == 0) req_v[b] = ~req_v[b];
            end
            done_v = 8'h00;
            for (int b = 0; b < 8; b++) begin
                if ($urandom_range(dlim - 1) == 0) done_v[b] = 1'b1;
            end
        end
        req_v = 8'h00;
        done_v = 8'h00;
        repeat (4) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
